prog_delay_timer: RTL and testbench
===================================

PROG_DELAY_TIMER -- requirements
Module: prog_delay_timer

Interface
REQ-001 Parameter CNT_W, default 18, SHALL set the tick counter, delay_ticks and remaining width.
REQ-002 Parameter PRE_W, default 8, SHALL set the prescale input width.
REQ-003 Parameter DEFAULT_TICKS, default 200000, SHALL set the tick count used when delay_ticks is 0; it SHALL fit in CNT_W bits.
REQ-004 clock  input  1  single rising-edge clock for all logic.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  request a delay; sampled only in IDLE.
REQ-007 abort  input  1  cancel a running delay.
REQ-008 mode  input  1  0 = one-shot, 1 = periodic; latched on start.
REQ-009 delay_ticks  input  CNT_W  delay length in units; latched on start.
REQ-010 prescale  input  PRE_W  unit length is prescale+1 clocks; latched on start.
REQ-011 busy  output  1  high while in RUN.
REQ-012 done  output  1  one-clock pulse at delay expiry.
REQ-013 remaining  output  CNT_W  units left in the current delay; 0 in IDLE.

Function
REQ-014 The FSM SHALL have exactly two states, IDLE and RUN.
REQ-015 In IDLE, start=1 at edge E0 SHALL:
  - latch mode, prescale as P, and delay_ticks as N (DEFAULT_TICKS if delay_ticks==0);
  - enter RUN with remaining=N, prescaler=0 and busy=1 after E0.
REQ-016 In RUN, the prescaler SHALL count 0..P and wrap to 0; remaining SHALL decrement by 1 on each wrap.
REQ-017 On the wrap that takes remaining from 1 to 0, done SHALL be 1 for the following clock only, at exactly N*(P+1) clocks after E0.
REQ-018 One-shot expiry, on the same edge that raises done:
  - state returns to IDLE;
  - busy=0 and remaining=0.
REQ-019 Periodic expiry, on the same edge that raises done:
  - state stays in RUN;
  - remaining reloads to N and the prescaler restarts at 0, so done recurs every N*(P+1) clocks.
REQ-020 Periodic mode SHALL run until abort or reset; delay_ticks, prescale and mode changes during RUN SHALL have no effect.
REQ-021 start during RUN SHALL be ignored.
REQ-022 abort=1 in RUN SHALL return the block to IDLE on the next edge with busy=0, remaining=0 and no done pulse.
REQ-023 abort SHALL take priority over an expiry on the same edge, so no done is produced.
REQ-024 start and abort together in IDLE: start SHALL win and abort SHALL be ignored.
REQ-025 abort in IDLE SHALL have no effect.
REQ-026 Minimum case N=1, P=0 SHALL give done 1 clock after E0; in periodic mode done SHALL then be high every clock.
REQ-027 All arithmetic SHALL be unsigned and SHALL never underflow below 0.
REQ-028 remaining SHALL update on the same edge as each prescaler wrap.
REQ-029 All outputs SHALL be registered.

Reset
REQ-030 reset_n=0 SHALL immediately force IDLE with busy=0, done=0, remaining=0, prescaler=0 and all latched values cleared.
REQ-031 Reset asserted mid-RUN SHALL abandon the delay with no done pulse.
REQ-032 After reset_n rises, the block SHALL wait in IDLE for a new start.

Verification
REQ-033 One-shot N=5, P=0:
  - start at E0 -> done high for one clock at E0+5;
  - busy high E0+1..E0+4 and low from E0+5;
  - remaining sequence 5,4,3,2,1,0.
REQ-034 Periodic N=3, P=2:
  - start at E0 -> done pulses at E0+9, E0+18 and E0+27;
  - abort at E0+20 -> IDLE at E0+21, no pulse at E0+27.
REQ-035 delay_ticks=0 with DEFAULT_TICKS=10, P=1, one-shot -> done at E0+20.
REQ-036 Collisions, one-shot N=4, P=0:
  - start re-asserted at E0+2 -> ignored, single done at E0+4;
  - abort at E0+3 (edge coinciding with expiry) -> no done, busy low at E0+4.
REQ-037 reset_n pulsed low at E0+3 of an N=8 run -> outputs 0 immediately, no done afterwards, new start accepted after release.

Source files
------------

// File: rtl/prog_delay_timer.sv
// prog_delay_timer
//    Programmable delay timer with a one-shot mode and a periodic mode.
//    A start request in IDLE latches the mode, the prescale value P and the
//    delay length N. Each unit lasts P+1 clocks. done pulses for one clock
//    every N*(P+1) clocks. In one-shot mode the block then returns to IDLE.
//    In periodic mode it reloads N and keeps running until abort or reset.
//
// Ports
//    clock        rising-edge clock for all logic
//    reset_n      asynchronous active-low reset
//    start        request a delay (sampled only in IDLE)
//    abort        cancel a running delay (ignored in IDLE)
//    mode         0 = one-shot, 1 = periodic (latched on start)
//    delay_ticks  delay length in units, 0 selects DEFAULT_TICKS (latched on start)
//    prescale     unit length minus one, in clocks (latched on start)
//    busy         high while in RUN
//    done         one-clock pulse at delay expiry
//    remaining    units left in the current delay, 0 in IDLE
//
// State | meaning
// IDLE  | waiting for start; outputs held at 0
// RUN   | counting units; the prescaler wraps every P+1 clocks

module prog_delay_timer #(
    parameter int CNT_W         = 18,
    parameter int PRE_W         = 8,
    parameter int DEFAULT_TICKS = 200000
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             abort,
    input  logic             mode,
    input  logic [CNT_W-1:0] delay_ticks,
    input  logic [PRE_W-1:0] prescale,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] remaining
);

    localparam logic [CNT_W-1:0] DEF_TICKS = CNT_W'(DEFAULT_TICKS);
    localparam logic [CNT_W-1:0] ONE_TICK  = CNT_W'(1);
    localparam logic [PRE_W-1:0] ONE_PRE   = PRE_W'(1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    logic [PRE_W-1:0] pre_cnt;
    logic [PRE_W-1:0] pre_max;
    logic [CNT_W-1:0] reload;
    logic             periodic;

    // Zero delay_ticks selects the default length, so a running delay is never 0.
    logic [CNT_W-1:0] start_ticks;
    assign start_ticks = (delay_ticks == '0) ? DEF_TICKS : delay_ticks;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            pre_cnt   <= '0;
            pre_max   <= '0;
            reload    <= '0;
            periodic  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            remaining <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // start wins over a simultaneous abort; abort alone does nothing here
                    if (start) begin
                        state     <= RUN;
                        periodic  <= mode;
                        pre_max   <= prescale;
                        reload    <= start_ticks;
                        remaining <= start_ticks;
                        pre_cnt   <= '0;
                        busy      <= 1'b1;
                    end
                end
                RUN: begin
                    if (abort) begin
                        // abort beats an expiry on the same edge, so no done here
                        state     <= IDLE;
                        pre_cnt   <= '0;
                        busy      <= 1'b0;
                        remaining <= '0;
                    end else if (pre_cnt == pre_max) begin
                        pre_cnt <= '0;
                        if (remaining <= ONE_TICK) begin
                            done <= 1'b1;
                            if (periodic) begin
                                remaining <= reload;
                            end else begin
                                state     <= IDLE;
                                busy      <= 1'b0;
                                remaining <= '0;
                            end
                        end else begin
                            remaining <= remaining - ONE_TICK;
                        end
                    end else begin
                        pre_cnt <= pre_cnt + ONE_PRE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    pre_cnt   <= '0;
                    busy      <= 1'b0;
                    remaining <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_delay_timer.sv
// tb_prog_delay_timer
//    Directed bench for prog_delay_timer with hand-computed expectations.
//    DEFAULT_TICKS is set to 10 so the zero-length case stays short.

module tb_prog_delay_timer;

    localparam int CNT_W = 18;
    localparam int PRE_W = 8;

    logic             clock;
    logic             reset_n;
    logic             start;
    logic             abort;
    logic             mode;
    logic [CNT_W-1:0] delay_ticks;
    logic [PRE_W-1:0] prescale;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] remaining;

    int n_tests;
    int n_fail;

    prog_delay_timer #(
        .CNT_W(CNT_W),
        .PRE_W(PRE_W),
        .DEFAULT_TICKS(10)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .start(start),
        .abort(abort),
        .mode(mode),
        .delay_ticks(delay_ticks),
        .prescale(prescale),
        .busy(busy),
        .done(done),
        .remaining(remaining)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance past one rising edge and settle 1 ns after it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Drive start for exactly one edge (that edge is E0); returns 1 ns after E0.
    task automatic start_run(input logic m, input int n, input int p);
        mode        = m;
        delay_ticks = CNT_W'(n);
        prescale    = PRE_W'(p);
        start       = 1'b1;
        step();
        start       = 1'b0;
    endtask

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        reset_n     = 1'b0;
        start       = 1'b0;
        abort       = 1'b0;
        mode        = 1'b0;
        delay_ticks = '0;
        prescale    = '0;

        #3;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_rem", 32'(remaining), 0);
        step();
        step();
        reset_n = 1'b1;
        step();

        // One-shot N=5 P=0: remaining 5,4,3,2,1,0 and done at E0+5
        start_run(1'b0, 5, 0);
        check("os5_busy_e0", 32'(busy), 1);
        check("os5_rem_e0", 32'(remaining), 5);
        check("os5_done_e0", 32'(done), 0);
        for (int k = 1; k <= 5; k++) begin
            step();
            check("os5_rem", 32'(remaining), 32'(5 - k));
            check("os5_busy", 32'(busy), (k < 5) ? 1 : 0);
            check("os5_done", 32'(done), (k == 5) ? 1 : 0);
        end
        step();
        check("os5_done_end", 32'(done), 0);
        check("os5_busy_end", 32'(busy), 0);

        // Periodic N=3 P=2: pulses at E0+9, E0+18; abort seen at E0+21
        start_run(1'b1, 3, 2);
        // changes during RUN must not matter
        mode        = 1'b0;
        delay_ticks = CNT_W'(7);
        prescale    = PRE_W'(0);
        check("per_rem_e0", 32'(remaining), 3);
        for (int k = 1; k <= 30; k++) begin
            step();
            if (k == 20) abort = 1'b1;
            if (k == 21) abort = 1'b0;
            check("per_done", 32'(done), (k == 9 || k == 18) ? 1 : 0);
            check("per_busy", 32'(busy), (k < 21) ? 1 : 0);
            check("per_rem", 32'(remaining), (k < 21) ? 32'(3 - (k % 9) / 3) : 0);
        end

        // delay_ticks=0 -> DEFAULT_TICKS=10, P=1: done at E0+20
        start_run(1'b0, 0, 1);
        check("def_rem_e0", 32'(remaining), 10);
        for (int k = 1; k <= 21; k++) begin
            step();
            check("def_done", 32'(done), (k == 20) ? 1 : 0);
            check("def_busy", 32'(busy), (k < 20) ? 1 : 0);
        end

        // One-shot N=4 P=0 with start re-asserted at E0+2: single done at E0+4
        start_run(1'b0, 4, 0);
        for (int k = 1; k <= 6; k++) begin
            step();
            start = (k == 1);
            check("rst_start_done", 32'(done), (k == 4) ? 1 : 0);
            check("rst_start_rem", 32'(remaining), (k < 4) ? 32'(4 - k) : 0);
        end
        start = 1'b0;

        // One-shot N=4 P=0 with abort sampled on the expiry edge: no done
        start_run(1'b0, 4, 0);
        for (int k = 1; k <= 6; k++) begin
            step();
            if (k == 3) abort = 1'b1;
            if (k == 4) abort = 1'b0;
            check("abt_exp_done", 32'(done), 0);
            check("abt_exp_busy", 32'(busy), (k < 4) ? 1 : 0);
        end

        // abort alone in IDLE does nothing; start+abort in IDLE starts
        abort = 1'b1;
        step();
        check("idle_abort_busy", 32'(busy), 0);
        check("idle_abort_rem", 32'(remaining), 0);
        mode        = 1'b0;
        delay_ticks = CNT_W'(6);
        prescale    = PRE_W'(0);
        start       = 1'b1;
        step();
        start = 1'b0;
        check("st_ab_busy", 32'(busy), 1);
        check("st_ab_rem", 32'(remaining), 6);
        step();
        check("run_abort_busy", 32'(busy), 0);
        check("run_abort_rem", 32'(remaining), 0);
        check("run_abort_done", 32'(done), 0);
        abort = 1'b0;

        // Minimum N=1 P=0 periodic: done every clock
        start_run(1'b1, 1, 0);
        for (int k = 1; k <= 4; k++) begin
            step();
            check("min_per_done", 32'(done), 1);
            check("min_per_rem", 32'(remaining), 1);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("min_per_abort_busy", 32'(busy), 0);
        check("min_per_abort_done", 32'(done), 0);

        // Minimum N=1 P=0 one-shot: done 1 clock after E0
        start_run(1'b0, 1, 0);
        step();
        check("min_os_done", 32'(done), 1);
        check("min_os_busy", 32'(busy), 0);

        // Reset mid-run of N=8 at E0+3
        start_run(1'b0, 8, 0);
        step();
        step();
        step();
        check("mid_rst_rem_pre", 32'(remaining), 5);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_rem", 32'(remaining), 0);
        check("mid_rst_done", 32'(done), 0);
        step();
        step();
        reset_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            check("post_rst_done", 32'(done), 0);
            check("post_rst_busy", 32'(busy), 0);
        end
        start_run(1'b0, 2, 0);
        check("post_rst_start", 32'(busy), 1);
        step();
        step();
        check("post_rst_new_done", 32'(done), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
